// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS  = 8;
  localparam int DEF_FLOOR_TICKS = 4;
  localparam int DEF_DOOR_TICKS  = 3;

  // Encodings are exactly the sim_state values seen by the display.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_DOOR = 2'b11
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Call-request / car-status bundle between the request source and the scheduler.
// Latency: n/a (wires only).  Backpressure: none; requests are level/pulse, status is free-running.
// Ports: tick, req[, estop] driven by master; destination, sim_state, cur_floor, door_open, busy by slave.
// Optional: ESTOP_EN adds the estop signal.
interface elevator_scheduler_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS
) ();
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  logic                  tick;
  logic [NUM_FLOORS-1:0] req;
`ifdef ESTOP_EN
  logic                  estop;
`endif
  logic [NUM_FLOORS-1:0] destination;
  logic [1:0]            sim_state;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  door_open;
  logic                  busy;

  modport master (
`ifdef ESTOP_EN
    output estop,
`endif
    output tick, req,
    input  destination, sim_state, cur_floor, door_open, busy
  );

  modport slave (
`ifdef ESTOP_EN
    input  estop,
`endif
    input  tick, req,
    output destination, sim_state, cur_floor, door_open, busy
  );
endinterface

// File: rtl/elevator_scheduler_floor_picker.sv
// Finds the nearest pending floor above and below the car (one-hot) plus any-above/any-below flags.
// Latency: combinational.  Backpressure: none.
// Ports: i_pending, i_cur_floor in; o_lowest_above, o_highest_below, o_any_above, o_any_below out.
module floor_picker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]    i_cur_floor,
  output logic [NUM_FLOORS-1:0] o_lowest_above,
  output logic [NUM_FLOORS-1:0] o_highest_below,
  output logic                  o_any_above,
  output logic                  o_any_below
);
  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;

  always_comb begin
    w_above = '0;
    w_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > i_cur_floor) w_above[i] = i_pending[i];
      if (FLOOR_W'(i) < i_cur_floor) w_below[i] = i_pending[i];
    end
  end

  // Isolate the lowest set bit with the two's-complement trick.
  assign o_lowest_above = w_above & (~w_above + NUM_FLOORS'(1));

  // Scan upward; the last hit is the highest floor below the car.
  always_comb begin
    o_highest_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_below[i]) begin
        o_highest_below    = '0;
        o_highest_below[i] = 1'b1;
      end
    end
  end

  assign o_any_above = |w_above;
  assign o_any_below = |w_below;
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: latches floor calls, runs IDLE/UP/DOWN/DOOR, tracks car floor.
// Latency: request visible in pending next clk; FSM/timers step only on tick; destination lags state/pending by 1 clk.
// Backpressure: none; requests are never refused, only merged into pending. Optional ESTOP_EN adds estop freeze.
// Ports: clk, rst (async active-high); bus (slave): tick, req[, estop] in; destination, sim_state, cur_floor, door_open, busy out.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_TICKS = DEF_FLOOR_TICKS,
  parameter int DOOR_TICKS  = DEF_DOOR_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  elevator_scheduler_if.slave bus
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int T_MAX   = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  state_t                r_state;
  dir_t                  r_dir;
  logic [FLOOR_W-1:0]    r_cur_floor;
  logic [TIMER_W-1:0]    r_timer;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] r_destination;

  state_t                w_next_state;
  dir_t                  w_next_dir;
  logic [FLOOR_W-1:0]    w_next_floor;
  logic [TIMER_W-1:0]    w_next_timer;
  logic [NUM_FLOORS-1:0] w_next_dest;
  logic [NUM_FLOORS-1:0] w_clear;
  logic [NUM_FLOORS-1:0] w_lowest_above;
  logic [NUM_FLOORS-1:0] w_highest_below;
  logic                  w_any_above;
  logic                  w_any_below;
  logic                  w_adv;
  logic [FLOOR_W-1:0]    w_floor_up;
  logic [FLOOR_W-1:0]    w_floor_dn;

`ifdef ESTOP_EN
  // estop freezes state and timer; door_open follows state so it stays high only if frozen in DOOR.
  assign w_adv = bus.tick & ~bus.estop;
`else
  assign w_adv = bus.tick;
`endif

  assign w_floor_up = r_cur_floor + FLOOR_W'(1);
  assign w_floor_dn = r_cur_floor - FLOOR_W'(1);

  floor_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_picker (
    .i_pending       (r_pending),
    .i_cur_floor     (r_cur_floor),
    .o_lowest_above  (w_lowest_above),
    .o_highest_below (w_highest_below),
    .o_any_above     (w_any_above),
    .o_any_below     (w_any_below)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_dir   = r_dir;
    w_next_floor = r_cur_floor;
    w_next_timer = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (r_pending[r_cur_floor]) begin
          w_next_state = ST_DOOR;
        end else if (w_any_above && (r_dir == DIR_UP || !w_any_below)) begin
          w_next_state = ST_UP;
          w_next_dir   = DIR_UP;
        end else if (w_any_below) begin
          w_next_state = ST_DOWN;
          w_next_dir   = DIR_DOWN;
        end
      end
      ST_UP, ST_DOWN: begin
        if (r_timer == TIMER_W'(FLOOR_TICKS - 1)) begin
          w_next_timer = '0;
          w_next_floor = (r_state == ST_UP) ? w_floor_up : w_floor_dn;
          // Stop at the floor just reached if it has a call.
          if (r_pending[w_next_floor]) w_next_state = ST_DOOR;
        end else begin
          w_next_timer = r_timer + TIMER_W'(1);
        end
      end
      ST_DOOR: begin
        if (r_timer == TIMER_W'(DOOR_TICKS - 1)) begin
          w_next_timer = '0;
          if (r_dir == DIR_UP) begin
            if (w_any_above) begin
              w_next_state = ST_UP;
            end else if (w_any_below) begin
              w_next_state = ST_DOWN;
              w_next_dir   = DIR_DOWN;
            end else begin
              w_next_state = ST_IDLE;
            end
          end else begin
            if (w_any_below) begin
              w_next_state = ST_DOWN;
            end else if (w_any_above) begin
              w_next_state = ST_UP;
              w_next_dir   = DIR_UP;
            end else begin
              w_next_state = ST_IDLE;
            end
          end
        end else begin
          w_next_timer = r_timer + TIMER_W'(1);
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Serviced floor is the one the car is at (or arriving at) while in/entering DOOR;
  // clearing it every such tick is what keeps a held call from extending the door.
  assign w_clear = (w_adv && (r_state == ST_DOOR || w_next_state == ST_DOOR))
                   ? (NUM_FLOORS'(1) << w_next_floor) : '0;

  always_comb begin
    case (r_state)
      ST_UP:   w_next_dest = w_lowest_above;
      ST_DOWN: w_next_dest = w_highest_below;
      default: w_next_dest = NUM_FLOORS'(1) << r_cur_floor;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_dir         <= DIR_UP;
      r_cur_floor   <= '0;
      r_timer       <= '0;
      r_pending     <= '0;
      r_destination <= NUM_FLOORS'(1);
    end else begin
      r_pending     <= (r_pending | bus.req) & ~w_clear;
      r_destination <= w_next_dest;
      if (w_adv) begin
        r_state     <= w_next_state;
        r_dir       <= w_next_dir;
        r_cur_floor <= w_next_floor;
        r_timer     <= w_next_timer;
      end
    end
  end

  assign bus.destination = r_destination;
  assign bus.sim_state   = r_state;
  assign bus.cur_floor   = r_cur_floor;
  assign bus.door_open   = (r_state == ST_DOOR);
  assign bus.busy        = (|r_pending) || (r_state != ST_IDLE);
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: vector table for single-car trips, hand sequences for
// reversal, async reset mid-move and (with ESTOP_EN) emergency stop.
// Expected values are hand-derived for NUM_FLOORS=8, FLOOR_TICKS=4, DOOR_TICKS=3.
module tb_elevator_scheduler;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_UP   = 2'b01;
  localparam logic [1:0] S_DOWN = 2'b10;
  localparam logic [1:0] S_DOOR = 2'b11;

  logic clk;
  logic rst;
  logic clk_en;
  int   checks;
  int   errors;

  elevator_scheduler_if #(.NUM_FLOORS(8)) bus ();

  elevator_scheduler #(
    .NUM_FLOORS  (8),
    .FLOOR_TICKS (4),
    .DOOR_TICKS  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic       tick;
    logic [7:0] req;
    int         ncyc;
    logic [1:0] st;
    logic [2:0] fl;
    logic [7:0] dest;
    logic       door;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input logic [7:0] r, input int n, input logic [1:0] s,
                     input logic [2:0] f, input logic [7:0] d, input logic o, input logic b);
    vec_t v;
    v.tick = t; v.req = r; v.ncyc = n; v.st = s; v.fl = f; v.dest = d; v.door = o; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [1:0] s, input logic [2:0] f,
                           input logic [7:0] d, input logic o, input logic b);
    check({nm, ".state"}, 32'(bus.sim_state), 32'(s));
    check({nm, ".floor"}, 32'(bus.cur_floor), 32'(f));
    check({nm, ".dest"},  32'(bus.destination), 32'(d));
    check({nm, ".door"},  32'(bus.door_open), 32'(o));
    check({nm, ".busy"},  32'(bus.busy), 32'(b));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] r);
    bus.req = r;
    step(1);
    bus.req = '0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
    int k = 0;
    while (bus.sim_state !== s && k < budget) begin
      step(1);
      k++;
    end
    check({nm, ".reached"}, 32'(bus.sim_state), 32'(s));
  endtask

  task automatic wait_floor(input logic [2:0] f, input int budget, input string nm);
    int k = 0;
    while (bus.cur_floor !== f && k < budget) begin
      step(1);
      k++;
    end
    check({nm, ".reached"}, 32'(bus.cur_floor), 32'(f));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    bus.tick = 1'b0;
    bus.req = '0;
`ifdef ESTOP_EN
    bus.estop = 1'b0;
`endif

    // Async reset with the clock stopped: values must appear without any edge.
    #1 rst = 1'b1;
    #20;
    check_all("reset", S_IDLE, 3'd0, 8'h01, 1'b0, 1'b0);
    clk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.tick = 1'b1;

    // Door at floor 0 with the call held; door must not stretch past 3 ticks.
    add(1, 8'h01, 1,  S_IDLE, 3'd0, 8'h01, 0, 1);
    add(1, 8'h01, 1,  S_DOOR, 3'd0, 8'h01, 1, 1);
    add(1, 8'h01, 3,  S_IDLE, 3'd0, 8'h01, 0, 0);
    add(1, 8'h00, 2,  S_IDLE, 3'd0, 8'h01, 0, 0);
    // Trip 0 -> 3: 4 ticks per floor, 3 door ticks.
    add(1, 8'h08, 1,  S_IDLE, 3'd0, 8'h01, 0, 1);
    add(1, 8'h00, 2,  S_UP,   3'd0, 8'h08, 0, 1);
    add(1, 8'h00, 3,  S_UP,   3'd1, 8'h08, 0, 1);
    add(1, 8'h00, 8,  S_DOOR, 3'd3, 8'h08, 1, 1);
    add(1, 8'h00, 1,  S_DOOR, 3'd3, 8'h08, 1, 1);
    add(1, 8'h00, 2,  S_IDLE, 3'd3, 8'h08, 0, 0);
    // tick held low: call captured but nothing moves.
    add(0, 8'h80, 1,  S_IDLE, 3'd3, 8'h08, 0, 1);
    add(0, 8'h00, 19, S_IDLE, 3'd3, 8'h08, 0, 1);
    add(1, 8'h00, 1,  S_UP,   3'd3, 8'h08, 0, 1);
    add(1, 8'h00, 1,  S_UP,   3'd3, 8'h80, 0, 1);
    add(1, 8'h00, 15, S_DOOR, 3'd7, 8'h80, 1, 1);
    add(1, 8'h00, 3,  S_IDLE, 3'd7, 8'h80, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.tick = vecs[i].tick;
      bus.req  = vecs[i].req;
      step(vecs[i].ncyc);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].dest,
                vecs[i].door, vecs[i].busy);
    end
    bus.tick = 1'b1;
    bus.req  = '0;

    // Down to 3, then up toward 6 with 1 and 5 called mid-move.
    pulse(8'h08);
    wait_state(S_DOOR, 40, "t3.door3");
    check("t3.floor3", 32'(bus.cur_floor), 32'd3);
    wait_state(S_IDLE, 10, "t3.idle3");
    pulse(8'h40);
    wait_state(S_UP, 5, "t3.up");
    step(2);
    pulse(8'h22);
    wait_state(S_DOOR, 20, "t3.door5");
    check("t3.floor5", 32'(bus.cur_floor), 32'd5);
    wait_state(S_UP, 10, "t3.resume");
    wait_state(S_DOOR, 20, "t3.door6");
    check("t3.floor6", 32'(bus.cur_floor), 32'd6);
    wait_state(S_DOWN, 10, "t3.reverse");
    check("t3.rev_floor", 32'(bus.cur_floor), 32'd6);
    step(1);
    check("t3.dest_down", 32'(bus.destination), 32'h02);
    wait_state(S_DOOR, 40, "t3.door1");
    check("t3.floor1", 32'(bus.cur_floor), 32'd1);
    wait_state(S_IDLE, 10, "t3.idle1");
    check("t3.busy", 32'(bus.busy), 32'd0);

    // Reset while moving between floors 2 and 3.
    pulse(8'h08);
    wait_state(S_UP, 5, "t6.up");
    wait_floor(3'd2, 10, "t6.floor2");
    step(2);
    #2 rst = 1'b1;
    #1;
    check_all("t6.rst", S_IDLE, 3'd0, 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(30);
    check_all("t6.after", S_IDLE, 3'd0, 8'h01, 1'b0, 1'b0);

`ifdef ESTOP_EN
    // Freeze 2 ticks into the 1->2 leg; the remaining 2 ticks complete after release.
    pulse(8'h08);
    wait_state(S_UP, 5, "es.up");
    wait_floor(3'd1, 10, "es.floor1");
    step(2);
    bus.estop = 1'b1;
    step(10);
    check("es.frozen_floor", 32'(bus.cur_floor), 32'd1);
    check("es.frozen_state", 32'(bus.sim_state), 32'(S_UP));
    bus.estop = 1'b0;
    step(1);
    check("es.resume_floor1", 32'(bus.cur_floor), 32'd1);
    step(1);
    check("es.resume_floor2", 32'(bus.cur_floor), 32'd2);
    wait_state(S_DOOR, 20, "es.door3");
    check("es.floor3", 32'(bus.cur_floor), 32'd3);
    wait_state(S_IDLE, 10, "es.idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- SCAN-style scheduler for the elevator car.
- Latches floor call requests, sequences the car through UP/DOWN/DOOR states and tracks the car position.
- Drives the `destination` and `sim_state` values consumed by the VGA display controller.
- Motion and door timing advance on a `tick` enable, normally the divided clock, so the display shows visible movement.

Parameters:
- NUM_FLOORS, 8: number of floors; width of `req` and `destination`.
- FLOOR_TICKS, 4: ticks to travel one floor (>=1).
- DOOR_TICKS, 3: ticks the door stays open (>=1).
- FLOOR_W, $clog2(NUM_FLOORS): localparam, width of `cur_floor`.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- tick  input  1  timing enable; FSM and timers advance only on cycles with tick=1
- req  input  NUM_FLOORS  call requests, bit i = floor i; any-cycle pulse or level
- destination  output  NUM_FLOORS  one-hot current target floor
- sim_state  output  2  00 IDLE, 01 UP, 10 DOWN, 11 DOOR
- cur_floor  output  FLOOR_W  current car floor
- door_open  output  1  high while in DOOR
- busy  output  1  high when pending != 0 or state != IDLE

Behaviour:
- Reset (async, immediate): state IDLE, cur_floor 0, dir UP, pending 0, timer 0, destination one-hot floor 0 (8'h01), door_open 0, busy 0.
- pending capture:
  - Every clk, independent of tick: pending <= (pending | req) & ~clear.
  - clear is one-hot cur_floor on any tick cycle where the car is in or entering DOOR.
  - A request for the serviced floor in the same cycle is absorbed; clear wins.
- above = pending bits > cur_floor; below = pending bits < cur_floor.
- IDLE (on tick):
  - pending[cur] set -> DOOR.
  - else above != 0 and (dir==UP or below==0) -> UP, dir=UP.
  - else below != 0 -> DOWN, dir=DOWN.
  - else stay IDLE.
- UP/DOWN:
  - timer counts ticks.
  - At timer==FLOOR_TICKS-1: cur_floor +/- 1, timer=0.
  - If pending[new floor] set -> DOOR on that same tick.
  - Otherwise continue in the same state.
  - The car never passes floor 0 or NUM_FLOORS-1: a move is only started with pending targets in that direction.
- DOOR:
  - door_open=1; timer counts DOOR_TICKS ticks.
  - Requests for cur_floor during DOOR are cleared and do not extend the door time.
  - At expiry:
    - pending targets in dir -> continue in dir.
    - else pending targets in the opposite direction -> reverse (dir flips).
    - else IDLE.
  - timer=0 on exit.
- destination:
  - UP: lowest pending floor above cur.
  - DOWN: highest pending floor below cur.
  - IDLE/DOOR: one-hot cur_floor.
  - Registered; updates the cycle after pending or state changes.
- sim_state and door_open are registered from the state.
- tick=0: state, timer and cur_floor hold; pending still captures.
- Reset mid-move or mid-door: all state is discarded and pending is lost.

Optional Feature:
- Macro ESTOP_EN.
- Defined:
  - Adds input `estop` (1 bit).
  - While estop=1: timer and state freeze, no floor change, door_open forced 1 only if already in DOOR.
  - pending still captures.
  - On release, operation resumes exactly where it stopped.
- Undefined: no `estop` port; behaviour as above.

Decomposition:
- Package elevator_pkg:
  - state_t enum, 2 bits, encodings matching the `sim_state` values above.
  - dir_t (UP/DOWN).
  - Defaults for NUM_FLOORS, FLOOR_TICKS, DOOR_TICKS.
- Sub-module floor_picker (combinational), given pending and cur_floor:
  - lowest_above (one-hot) and highest_below (one-hot).
  - any_above and any_below flags.

Test Plan (tick=1 every cycle unless stated; FLOOR_TICKS=4, DOOR_TICKS=3):
1. Assert rst for 2 cycles with no clock edge in between -> sim_state=00, cur_floor=0, destination=8'h01, door_open=0 immediately.
2. Idle at floor 0, pulse req=8'h08 for 1 cycle:
   - -> sim_state=01, destination=8'h08.
   - cur_floor increments every 4 ticks, reaching 3 after 12 ticks.
   - DOOR for 3 ticks with door_open=1, then IDLE, busy=0.
3. Moving UP from floor 3 toward 6, pulse req=8'h22 (floors 1 and 5) -> stops at 5 (DOOR), then 6, then reverses to DOWN, destination=8'h02, stops at 1.
4. Idle at floor 0, req=8'h01 -> DOOR on next tick, cur_floor stays 0, pending clears; holding req=8'h01 during DOOR does not extend it past 3 ticks.
5. tick held 0 for 20 cycles while pulsing req=8'h80 -> state and cur_floor unchanged, busy=1; motion begins on the first tick=1.
6. rst asserted while UP between floors 2 and 3 -> immediate reset values; pending 0, so the car stays IDLE at floor 0 after release.
   - With ESTOP_EN: estop=1 for 10 cycles mid-move freezes cur_floor and timer; the remaining travel completes after release.
